// File: rtl/uop_fu_scheduler.sv
// Round-robin sharing of one pipelined microop unit among N requesters.
// Enforces II spacing and routes each result back to its issuer through a LAT+1 tag pipeline.
module uop_fu_scheduler #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 64,
  parameter int unsigned SW  = $clog2(W),
  parameter int unsigned LAT = 3,
  parameter int unsigned II  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  input  logic [N*SW-1:0] req_shamt,
  output logic [N-1:0]    req_ready,
  output logic            fu_issue,
  output logic [W-1:0]    fu_a,
  output logic [W-1:0]    fu_b,
  output logic [SW-1:0]   fu_shamt,
  input  logic [W-1:0]    fu_y,
  output logic [N-1:0]    rsp_valid,
  output logic [W-1:0]    rsp_y,
  output logic            busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (II > 1) ? $clog2(II) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [CW-1:0] r_cnt;
  logic [LAT:0]  r_tag_v;
  logic [IW-1:0] r_tag_id [0:LAT];

  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_gnt_id;
  logic          w_can_grant;
  logic          w_hs;
  logic [IW-1:0] w_rr_next;

  // First asserted request at or after rr_ptr, wrapping modulo N.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_gnt_id = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % int'(N));
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  assign w_can_grant = !rst && !flush && (r_state == S_IDLE);
  assign w_hs        = w_can_grant && w_found;
  assign req_ready   = w_hs ? (N'(1) << w_gnt_id) : '0;
  assign w_rr_next   = (w_gnt_id == IW'(N - 1)) ? '0 : w_gnt_id + IW'(1);
  assign busy        = (r_state != S_IDLE) || (|r_tag_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_tag_v   <= '0;
      for (int k = 0; k <= int'(LAT); k++) r_tag_id[k] <= '0;
      fu_issue  <= 1'b0;
      fu_a      <= '0;
      fu_b      <= '0;
      fu_shamt  <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      fu_issue <= w_hs;
      if (w_hs) begin
        fu_a     <= req_a[w_gnt_id*W +: W];
        fu_b     <= req_b[w_gnt_id*W +: W];
        fu_shamt <= req_shamt[w_gnt_id*SW +: SW];
        r_rr_ptr <= w_rr_next;
      end

      // Tag shift register; a flush kills every in-flight tag.
      r_tag_v[0]  <= w_hs;
      r_tag_id[0] <= w_gnt_id;
      for (int k = 1; k <= int'(LAT); k++) begin
        r_tag_v[k]  <= !flush && r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end

      // fu_y is sampled in the cycle the tag leaves the last stage.
      if (!flush && r_tag_v[LAT]) begin
        rsp_valid <= N'(1) << r_tag_id[LAT];
        rsp_y     <= fu_y;
      end else begin
        rsp_valid <= '0;
      end

      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_hs && (II > 1)) begin
              r_state <= S_HOLD;
              r_cnt   <= CW'(II - 1);
            end
          end
          S_HOLD: begin
            if (r_cnt <= CW'(1)) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
